// File: rtl/bus_fifo_pkg.sv
// Shared bus-width constants and beat packing helper for the 64->128 packing FIFO.
package bus_fifo_pkg;
  localparam int BUS_WORD_W         = 64;
  localparam int BUS_BEAT_W         = 128;
  localparam int DEFAULT_FIFO_DEPTH = 32;

  typedef logic [BUS_WORD_W-1:0] word_t;
  typedef logic [BUS_BEAT_W-1:0] beat_t;

  // Older word sits in the low half of the beat.
  function automatic beat_t pack_beat(input word_t older, input word_t younger);
    return {younger, older};
  endfunction
endpackage

// File: rtl/bus_pack_fifo_if.sv
// Handshake/status bundle of bus_pack_fifo; slave is the FIFO side, master the producer/consumer side.
interface bus_pack_fifo_if #(parameter int DEPTH = bus_fifo_pkg::DEFAULT_FIFO_DEPTH);
  import bus_fifo_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          write_en;
  word_t         write_data;
  logic          read_en;
  beat_t         read_data;
  logic          read_valid;
  logic          fifo_full;
  logic          fifo_half_full;
  logic          fifo_empty;
  logic [CW-1:0] word_count;
  logic          overflow;
  logic          underflow;

  modport master (
    output write_en, write_data, read_en,
    input  read_data, read_valid, fifo_full, fifo_half_full, fifo_empty,
           word_count, overflow, underflow
  );

  modport slave (
    input  write_en, write_data, read_en,
    output read_data, read_valid, fifo_full, fifo_half_full, fifo_empty,
           word_count, overflow, underflow
  );
endinterface

// File: rtl/bus_pack_ram.sv
// Word-write / beat-read storage: split into even and odd banks so one row read yields a full beat.
module bus_pack_ram
  import bus_fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  word_t         i_wdata,
  input  logic          i_re,
  input  logic [AW-2:0] i_rrow,
  output beat_t         o_rdata
);
  word_t r_even [DEPTH/2];
  word_t r_odd  [DEPTH/2];
  beat_t r_rdata;

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      if (i_waddr[0]) r_odd[i_waddr[AW-1:1]]  <= i_wdata;
      else            r_even[i_waddr[AW-1:1]] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      r_rdata <= '0;
    else if (i_re) r_rdata <= pack_beat(r_even[i_rrow], r_odd[i_rrow]);
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/bus_pack_fifo.sv
// 64-bit word in, 128-bit beat out FIFO with sticky overflow/underflow.
// Optional BUS_PACK_FIFO_FLUSH_EN adds a flush input that zero-pads an odd trailing word.
module bus_pack_fifo
  import bus_fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input logic             clk,
  input logic             rst,
`ifdef BUS_PACK_FIFO_FLUSH_EN
  input logic             flush,
`endif
  bus_pack_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-2:0] r_rd_row;   // read pointer in beats; word address is {r_rd_row, 1'b0}
  logic [CW-1:0] r_count;
  logic          r_read_valid;
  logic          r_overflow;
  logic          r_underflow;

  logic          w_full, w_empty, w_half;
  logic          w_wr_acc, w_rd_acc, w_pad;
  logic          w_ram_we;
  word_t         w_ram_wdata;
  beat_t         w_rdata;
  logic [CW-1:0] w_count_nxt;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count <  CW'(2));
  assign w_half   = (r_count >= CW'(DEPTH/2));

  assign w_wr_acc = bus.write_en && !w_full;
  assign w_rd_acc = bus.read_en  && !w_empty;

`ifdef BUS_PACK_FIFO_FLUSH_EN
  // Padding only completes a half beat and never competes with a real write.
  assign w_pad = flush && r_count[0] && !bus.write_en && !w_full;
`else
  assign w_pad = 1'b0;
`endif

  assign w_ram_we    = w_wr_acc || w_pad;
  assign w_ram_wdata = w_pad ? '0 : bus.write_data;

  always_comb begin
    w_count_nxt = r_count;
    if (w_ram_we) w_count_nxt = w_count_nxt + CW'(1);
    if (w_rd_acc) w_count_nxt = w_count_nxt - CW'(2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr     <= '0;
      r_rd_row     <= '0;
      r_count      <= '0;
      r_read_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      if (w_ram_we) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_acc) r_rd_row <= r_rd_row + (AW-1)'(1);
      r_count      <= w_count_nxt;
      r_read_valid <= w_rd_acc;
      if (bus.write_en && w_full)  r_overflow  <= 1'b1;
      if (bus.read_en  && w_empty) r_underflow <= 1'b1;
    end
  end

  bus_pack_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_ram_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_ram_wdata),
    .i_re    (w_rd_acc),
    .i_rrow  (r_rd_row),
    .o_rdata (w_rdata)
  );

  assign bus.read_data      = w_rdata;
  assign bus.read_valid     = r_read_valid;
  assign bus.fifo_full      = w_full;
  assign bus.fifo_half_full = w_half;
  assign bus.fifo_empty     = w_empty;
  assign bus.word_count     = r_count;
  assign bus.overflow       = r_overflow;
  assign bus.underflow      = r_underflow;
endmodule

// File: tb/tb_bus_pack_fifo.sv
// Scoreboard bench for bus_pack_fifo: word-queue reference model, beat monitor on read_valid.
module tb_bus_pack_fifo;
  import bus_fifo_pkg::*;
  localparam int DEPTH = 32;
`ifdef BUS_PACK_FIFO_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
  logic flush = 1'b0;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  bus_pack_fifo_if #(.DEPTH(DEPTH)) bif();

  bus_pack_fifo #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef BUS_PACK_FIFO_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

  word_t mq[$];
  beat_t exp_q[$];
  beat_t last_beat = '0;
  bit    m_ovf, m_unf;
  int    n_chk = 0, n_fail = 0, beats_seen = 0;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic word_t rnd_word();
    return {$urandom, $urandom};
  endfunction

  // Monitor: read_valid must appear exactly one cycle after each accepted read.
  initial begin
    forever begin
      @(negedge clk);
      chk("read_valid", 128'(bif.read_valid), 128'(exp_q.size() != 0));
      if (bif.read_valid && exp_q.size() != 0) begin
        last_beat = exp_q.pop_front();
        beats_seen++;
        chk("beat", bif.read_data, last_beat);
      end else if (!bif.read_valid) begin
        exp_q.delete();
        chk("read_data_hold", bif.read_data, last_beat);
      end
    end
  end

  task automatic check_state();
    chk("word_count", 128'(bif.word_count), 128'(mq.size()));
    chk("fifo_full",  128'(bif.fifo_full),  128'(mq.size() == DEPTH));
    chk("fifo_half",  128'(bif.fifo_half_full), 128'(mq.size() >= DEPTH/2));
    chk("fifo_empty", 128'(bif.fifo_empty), 128'(mq.size() < 2));
    chk("overflow",   128'(bif.overflow),   128'(m_ovf));
    chk("underflow",  128'(bif.underflow),  128'(m_unf));
  endtask

  task automatic cycle(input bit we, input word_t wd, input bit re, input bit fl);
    int pre;
    word_t w0, w1;
    @(negedge clk);
    bif.write_en   = we;
    bif.write_data = wd;
    bif.read_en    = re;
`ifdef BUS_PACK_FIFO_FLUSH_EN
    flush = fl;
`endif
    @(posedge clk);
    pre = mq.size();
    if (re) begin
      if (pre >= 2) begin
        w0 = mq.pop_front();
        w1 = mq.pop_front();
        exp_q.push_back({w1, w0});
      end else m_unf = 1'b1;
    end
    if (we) begin
      if (pre < DEPTH) mq.push_back(wd);
      else m_ovf = 1'b1;
    end else if (FLUSH_EN && fl && (pre % 2 == 1) && pre < DEPTH) begin
      mq.push_back('0);
    end
    #1 check_state();
  endtask

  task automatic idle();
    bif.write_en   = 1'b0;
    bif.write_data = '0;
    bif.read_en    = 1'b0;
`ifdef BUS_PACK_FIFO_FLUSH_EN
    flush = 1'b0;
`endif
  endtask

  // Asserts reset between clock edges and checks outputs clear without waiting for a clock.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    idle();
    mq.delete();
    exp_q.delete();
    last_beat = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #1;
    chk("rst_read_valid", 128'(bif.read_valid), 128'(0));
    chk("rst_read_data",  bif.read_data, 128'(0));
    check_state();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int start;
    idle();
    #1;
    chk("init_read_data", bif.read_data, 128'(0));
    check_state();
    do_reset();

    // Basic pair
    cycle(1, 64'h1111, 0, 0);
    cycle(1, 64'h2222, 0, 0);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 0, 0);

    // Fill to full, then one rejected write
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1, rnd_word(), 0, 0);
    cycle(1, 64'hDEAD_BEEF, 0, 0);
    for (int i = 0; i < DEPTH/2; i++) cycle(0, '0, 1, 0);
    cycle(0, '0, 0, 0);

    // Simultaneous write and read at count 3, and read/write at full
    do_reset();
    cycle(1, 64'hA0, 0, 0);
    cycle(1, 64'hA1, 0, 0);
    cycle(1, 64'hA2, 0, 0);
    cycle(1, 64'hA3, 1, 0);
    cycle(0, '0, 1, 0);
    for (int i = 0; i < DEPTH; i++) cycle(1, rnd_word(), 0, 0);
    cycle(1, 64'hBAD, 1, 0);
    cycle(0, '0, 0, 0);

    // Odd trailing word: underflow, then optional zero pad
    do_reset();
    cycle(1, 64'h5555, 0, 0);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 0, 1);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 0, 0);

    // Streaming across pointer wrap
    do_reset();
    start = beats_seen;
    for (int i = 0; i < 100; i++) cycle(1, 64'h1000 + 64'(i), mq.size() >= 2, 0);
    while (mq.size() >= 2) cycle(0, '0, 1, 0);
    cycle(0, '0, 0, 0);
    chk("stream_beats", 128'(beats_seen - start), 128'(50));

    // Reset mid-stream, then fresh data only
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1, rnd_word(), 0, 0);
    do_reset();
    cycle(1, 64'hCAFE_0001, 0, 0);
    cycle(1, 64'hCAFE_0002, 0, 0);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 0, 0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      cycle($urandom_range(0, 99) < 55, rnd_word(), $urandom_range(0, 99) < 45,
            $urandom_range(0, 9) == 0);
    end
    cycle(0, '0, 0, 0);
    cycle(0, '0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_pack_fifo.md
BUS_PACK_FIFO -- requirements
Module: bus_pack_fifo

Interface
REQ-001 SHALL have parameter: DEPTH, 32, capacity in 64-bit words; power of two, even, >=4.
REQ-002 SHALL have port: clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: write_en  input  1  push one 64-bit word.
REQ-005 SHALL have port: write_data  input  64  word to push.
REQ-006 SHALL have port: read_en  input  1  pop one 128-bit beat (two words).
REQ-007 SHALL have port: read_data  output  128  registered beat: [63:0] older word, [127:64] younger word.
REQ-008 SHALL have port: read_valid  output  1  one-cycle pulse marking read_data updated.
REQ-009 SHALL have port: fifo_full  output  1  count == DEPTH.
REQ-010 SHALL have port: fifo_half_full  output  1  count >= DEPTH/2.
REQ-011 SHALL have port: fifo_empty  output  1  count < 2, i.e. no complete beat.
REQ-012 SHALL have port: word_count  output  $clog2(DEPTH)+1  stored words.
REQ-013 SHALL have port: overflow  output  1  sticky; write attempted while full.
REQ-014 SHALL have port: underflow  output  1  sticky; read attempted while fifo_empty.

Function
REQ-015 SHALL accept a write iff write_en && !fifo_full: mem[wr_ptr] <= write_data, wr_ptr += 1 (modulo DEPTH).
REQ-016 SHALL accept a read iff read_en && !fifo_empty: read_data <= {mem[rd_ptr+1], mem[rd_ptr]}, rd_ptr += 2 (modulo DEPTH), read_valid = 1 next cycle.
REQ-017 SHALL have read latency of exactly one cycle; read_data holds its value when no read is accepted.
REQ-018 SHALL update count as: +1 write only; -2 read only; -1 both accepted in the same cycle; unchanged otherwise.
REQ-019 SHALL evaluate full/empty from the pre-edge count, so simultaneous write-at-full and read both resolve per REQ-015/016 (write rejected at full).
REQ-020 SHALL ignore rejected requests except for setting overflow/underflow; pointers, count and memory stay unchanged.
REQ-021 SHALL wrap pointers naturally at DEPTH; beat {mem[DEPTH-1], mem[0]} is never formed because rd_ptr stays even.
REQ-022 SHALL keep an odd trailing word stored and fifo_empty high until its partner word arrives.

Reset
REQ-023 SHALL, on rst low, immediately clear wr_ptr, rd_ptr, count, read_data (all zero), read_valid, overflow, underflow.
REQ-024 SHALL not reset memory contents; reset mid-operation discards all stored words and any pending beat.
REQ-025 SHALL produce fifo_empty=1, fifo_full=0, fifo_half_full=0 during and after reset.

Configuration
REQ-026 SHALL, with BUS_PACK_FIFO_FLUSH_EN defined, add input flush (1 bit): when flush && count odd && !write_en && !fifo_full, write 64'h0 at wr_ptr and count += 1, completing the beat; otherwise flush has no effect.
REQ-027 SHALL, without BUS_PACK_FIFO_FLUSH_EN, omit the flush port and padding logic entirely.

Structure
REQ-028 SHALL take BUS_WORD_W=64, BUS_BEAT_W=128 and DEFAULT_FIFO_DEPTH=32 from shared package bus_fifo_pkg.
REQ-029 SHALL place storage in sub-module bus_pack_ram: one 64-bit write port, one 128-bit registered read port at even addresses.

Verification
REQ-030 SHALL cover: reset, write 64'h1111, 64'h2222, read -> next cycle read_valid=1, read_data=128'h0000...2222_0000...1111, count=0.
REQ-031 SHALL cover: 32 writes -> fifo_full=1 and half_full=1; 33rd write -> ignored, overflow=1, count=32.
REQ-032 SHALL cover: count=3, simultaneous write and read -> count=2, beat = words 0,1, next read returns words 2,3.
REQ-033 SHALL cover: one write then read -> underflow=1, read_valid=0, count=1; with FLUSH_EN, flush then read -> read_data={64'h0, word}.
REQ-034 SHALL cover: 100 words streamed continuously with reads whenever !fifo_empty -> 50 beats in order across pointer wrap, no flags.
REQ-035 SHALL cover: rst low mid-stream with count=10 -> all outputs reset immediately; post-reset write/read pair returns only new data.
